// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth math, Gray decode, popcount.
// Sync-depth limits for the pointer synchronisers.
package fifo_pkg;

  localparam int unsigned MAX_PTRW  = 32;
  localparam int          SYNC_MIN  = 2;
  localparam int          SYNC_MAX  = 4;

  function automatic int unsigned depth_of(
    input int unsigned aw
  );
    return int'(1) << aw;
  endfunction

  // Zero-extended Gray decodes correctly at any
  // narrower width: the leading zeros leave the
  // running XOR untouched.
  function automatic logic [MAX_PTRW-1:0] gray2bin(
    input logic [MAX_PTRW-1:0] g
  );
    logic [MAX_PTRW-1:0] b;
    b = g;
    for (int i = MAX_PTRW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned popcount(
    input logic [MAX_PTRW-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_PTRW; i++)
      n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sync_r2w_status_if.sv
// Read-pointer / status bundle of the write-side synchroniser.
// slave: the synchroniser; master: whoever drives pointers.
interface sync_r2w_status_if #(
  parameter int ADDRSIZE = 4
);

  logic [ADDRSIZE:0] rptr;
  logic [ADDRSIZE:0] wbin;
  logic              wclr_err;
  logic [ADDRSIZE:0] wq_rptr;
  logic [ADDRSIZE:0] wq_rbin;
  logic [ADDRSIZE:0] wlevel;
  logic              wfull;
  logic              wafull;
  logic              wgray_err;
  logic              wptr_err;

  modport slave (
    input  rptr, wbin, wclr_err,
    output wq_rptr, wq_rbin, wlevel,
    output wfull, wafull,
    output wgray_err, wptr_err
  );

  modport master (
    output rptr, wbin, wclr_err,
    input  wq_rptr, wq_rbin, wlevel,
    input  wfull, wafull,
    input  wgray_err, wptr_err
  );

endinterface

// File: rtl/sync_nff.sv
// Generic multi-bit N-flop synchroniser chain, pure flops.
// Ports: clk, rst_n (async low), d in, q = last stage.
module sync_nff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/sync_r2w_status.sv
// Read pointer into wclk, Gray->bin, level/full/afull, sticky
// pointer faults. Ports: wclk, wrst_n, bus (slave modport).
module sync_r2w_status
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  sync_r2w_status_if.slave    bus
);

  localparam int PW    = ADDRSIZE + 1;
  localparam int DEPTH = int'(depth_of(ADDRSIZE));

  localparam logic [PW-1:0] DEPTH_V =
    PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_V =
    PW'(DEPTH - AFULL_MARGIN);
  localparam logic [2:0] WARM =
    3'(SYNC_STAGES + 1);

  if (SYNC_STAGES < SYNC_MIN ||
      SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end

  if (AFULL_MARGIN < 1 ||
      AFULL_MARGIN > DEPTH - 1) begin : g_bad_afull
    $error("AFULL_MARGIN out of range");
  end

  logic [PW-1:0] q_rptr;
  logic [PW-1:0] rbin_q;
  logic [PW-1:0] prev_q;
  logic [PW-1:0] lvl;
  logic [PW-1:0] level_q;
  logic          full_q;
  logic          afull_q;
  logic          gerr_q;
  logic          perr_q;
  logic [2:0]    warm_q;
  logic          chk_en;
  logic          gray_set;
  logic          ptr_set;

  sync_nff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (bus.rptr),
    .q     (q_rptr)
  );

  // Until the chain has flushed, prev still holds reset
  // zeros rather than a sampled pointer, so the Gray check
  // stays off for the first SYNC_STAGES+1 edges.
  assign chk_en = (warm_q == WARM);

  assign lvl = bus.wbin - rbin_q;

  assign gray_set = chk_en &&
    (popcount(MAX_PTRW'(q_rptr ^ prev_q)) > 1);

  assign ptr_set = (lvl > DEPTH_V);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      warm_q  <= '0;
      rbin_q  <= '0;
      prev_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      gerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      if (!chk_en)
        warm_q <= warm_q + 3'd1;
      rbin_q  <= PW'(gray2bin(MAX_PTRW'(q_rptr)));
      prev_q  <= q_rptr;
      level_q <= lvl;
      full_q  <= (lvl >= DEPTH_V);
      afull_q <= (lvl >= AFULL_V);
      gerr_q  <= gray_set |
                 (gerr_q & ~bus.wclr_err);
      perr_q  <= ptr_set |
                 (perr_q & ~bus.wclr_err);
    end
  end

  assign bus.wq_rptr   = q_rptr;
  assign bus.wq_rbin   = rbin_q;
  assign bus.wlevel    = level_q;
  assign bus.wfull     = full_q;
  assign bus.wafull    = afull_q;
  assign bus.wgray_err = gerr_q;
  assign bus.wptr_err  = perr_q;

endmodule
